// File: rtl/vga_pkg.sv
// Shared raster timing constants (640x480@60) and the player state encodings
// used by the renderer and game logic.
package vga_pkg;

  localparam int CNT_W = 10;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  typedef enum logic [3:0] {
    PS_IDLE      = 4'd0,
    PS_WALK      = 4'd1,
    PS_RUN       = 4'd2,
    PS_JUMP      = 4'd3,
    PS_FALL      = 4'd4,
    PS_PUNCH     = 4'd5,
    PS_KICK      = 4'd6,
    PS_BLOCK     = 4'd7,
    PS_HIT       = 4'd8,
    PS_KO        = 4'd9,
    PS_BLOCKSTUN = 4'd10
  } player_state_e;

endpackage

// File: rtl/vga_sync_delay.sv
// DEPTH-stage shift register that realigns sync/blank with the renderer's
// registered RGB. DEPTH=0 collapses to wires.
module vga_sync_delay #(
  parameter int DEPTH = 1,
  parameter int W     = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] rst_val,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  if (DEPTH == 0) begin : g_wire
    assign q = d;
  end else begin : g_pipe
    logic [DEPTH-1:0][W-1:0] pipe;

    // every stage reloads the idle value so no stale pulse drains out after reset
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        pipe <= {DEPTH{rst_val}};
      end else begin
        pipe[0] <= d;
        for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
      end
    end

    assign q = pipe[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster scan generator: h/v counters, zero-latency area/strobe decode, and
// sync/blank outputs delayed to match the renderer pipeline.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE   = VGA_H_ACTIVE,
  parameter int H_FP       = VGA_H_FP,
  parameter int H_SYNC     = VGA_H_SYNC,
  parameter int H_BP       = VGA_H_BP,
  parameter int V_ACTIVE   = VGA_V_ACTIVE,
  parameter int V_FP       = VGA_V_FP,
  parameter int V_SYNC     = VGA_V_SYNC,
  parameter int V_BP       = VGA_V_BP,
  parameter bit HS_ACTIVE  = 1'b0,
  parameter bit VS_ACTIVE  = 1'b0,
  parameter int SYNC_DELAY = 1
) (
  input  logic             vga_clk,
  input  logic             rst_n,
  output logic [CNT_W-1:0] h_count,
  output logic [CNT_W-1:0] v_count,
  output logic             display_area,
  output logic             line_start,
  output logic             frame_start,
  output logic             frame_end,
  output logic             hsync,
  output logic             vsync,
  output logic             blank_n
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_LO = CNT_W'(V_ACTIVE - 1);
  localparam logic [CNT_W-1:0] HS_ON    = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_OFF   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_ON    = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_OFF   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic       hs_raw, vs_raw;
  logic [2:0] dly_q;

  always_ff @(posedge vga_clk) begin
    if (!rst_n) begin
      h_count <= '0;
      v_count <= '0;
    end else if (h_count == H_LAST) begin
      h_count <= '0;
      v_count <= (v_count == V_LAST) ? '0 : v_count + 1'b1;
    end else begin
      h_count <= h_count + 1'b1;
    end
  end

  // decoded straight off the registered counts: glitch-free, same-cycle
  assign display_area = (h_count < H_ACT) && (v_count < V_ACT);
  assign line_start   = (h_count == '0);
  assign frame_start  = (h_count == '0) && (v_count == '0);
  assign frame_end    = (h_count == H_ACT) && (v_count == V_ACT_LO);

  assign hs_raw = ((h_count >= HS_ON) && (h_count < HS_OFF)) ? HS_ACTIVE : ~HS_ACTIVE;
  assign vs_raw = ((v_count >= VS_ON) && (v_count < VS_OFF)) ? VS_ACTIVE : ~VS_ACTIVE;

  vga_sync_delay #(
    .DEPTH (SYNC_DELAY),
    .W     (3)
  ) u_sync_delay (
    .clk     (vga_clk),
    .rst_n   (rst_n),
    .rst_val ({~HS_ACTIVE, ~VS_ACTIVE, 1'b0}),
    .d       ({hs_raw, vs_raw, display_area}),
    .q       (dly_q)
  );

  assign {hsync, vsync, blank_n} = dly_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full 640x480 timing for line-level checks, plus a shrunken
// raster at delays 0/1/3 for frame-level counts, delay alignment and reset abort.
module tb_vga_timing_gen;

  // small raster: H 16+2+4+3=25, V 6+2+2+3=13, frame = 325 clocks
  localparam int SH_A = 16, SH_F = 2, SH_S = 4, SH_B = 3;
  localparam int SV_A = 6,  SV_F = 2, SV_S = 2, SV_B = 3;

  logic vga_clk = 1'b0;
  logic rst_n   = 1'b0;
  always #5 vga_clk = ~vga_clk;

  logic [9:0] f_h, f_v;
  logic       f_da, f_ls, f_fs, f_fe, f_hs, f_vs, f_bn;
  logic [9:0] s0_h, s0_v, s1_h, s1_v, s3_h, s3_v;
  logic       s0_da, s0_ls, s0_fs, s0_fe, s0_hs, s0_vs, s0_bn;
  logic       s1_da, s1_ls, s1_fs, s1_fe, s1_hs, s1_vs, s1_bn;
  logic       s3_da, s3_ls, s3_fs, s3_fe, s3_hs, s3_vs, s3_bn;

  vga_timing_gen u_full (
    .vga_clk(vga_clk), .rst_n(rst_n), .h_count(f_h), .v_count(f_v),
    .display_area(f_da), .line_start(f_ls), .frame_start(f_fs), .frame_end(f_fe),
    .hsync(f_hs), .vsync(f_vs), .blank_n(f_bn)
  );

  vga_timing_gen #(
    .H_ACTIVE(SH_A), .H_FP(SH_F), .H_SYNC(SH_S), .H_BP(SH_B),
    .V_ACTIVE(SV_A), .V_FP(SV_F), .V_SYNC(SV_S), .V_BP(SV_B), .SYNC_DELAY(0)
  ) u_s0 (
    .vga_clk(vga_clk), .rst_n(rst_n), .h_count(s0_h), .v_count(s0_v),
    .display_area(s0_da), .line_start(s0_ls), .frame_start(s0_fs), .frame_end(s0_fe),
    .hsync(s0_hs), .vsync(s0_vs), .blank_n(s0_bn)
  );

  vga_timing_gen #(
    .H_ACTIVE(SH_A), .H_FP(SH_F), .H_SYNC(SH_S), .H_BP(SH_B),
    .V_ACTIVE(SV_A), .V_FP(SV_F), .V_SYNC(SV_S), .V_BP(SV_B), .SYNC_DELAY(1)
  ) u_s1 (
    .vga_clk(vga_clk), .rst_n(rst_n), .h_count(s1_h), .v_count(s1_v),
    .display_area(s1_da), .line_start(s1_ls), .frame_start(s1_fs), .frame_end(s1_fe),
    .hsync(s1_hs), .vsync(s1_vs), .blank_n(s1_bn)
  );

  vga_timing_gen #(
    .H_ACTIVE(SH_A), .H_FP(SH_F), .H_SYNC(SH_S), .H_BP(SH_B),
    .V_ACTIVE(SV_A), .V_FP(SV_F), .V_SYNC(SV_S), .V_BP(SV_B), .SYNC_DELAY(3)
  ) u_s3 (
    .vga_clk(vga_clk), .rst_n(rst_n), .h_count(s3_h), .v_count(s3_v),
    .display_area(s3_da), .line_start(s3_ls), .frame_start(s3_fs), .frame_end(s3_fe),
    .hsync(s3_hs), .vsync(s3_vs), .blank_n(s3_bn)
  );

  logic [2:0] fs_v, da_v, vs_v, fe_v;
  assign fs_v = {s3_fs, s1_fs, s0_fs};
  assign da_v = {s3_da, s1_da, s0_da};
  assign vs_v = {s3_vs, s1_vs, s0_vs};
  assign fe_v = {s3_fe, s1_fe, s0_fe};

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge vga_clk);
    @(negedge vga_clk);
  endtask

  logic       s0_hs_hist [0:800];
  logic       s0_bn_hist [0:800];
  int         f_lo_cnt = 0, f_first_lo = -1, f_last_lo = -1, f_vchg = 0;
  int         s0_lo_line0 = 0, s0_first_lo = -1;
  int         sh1_err = 0, sh3_err = 0, s3_early = 0;
  int         fs2 [3], da_cnt [3], vs_cnt [3], fe_at [3];
  logic [9:0] prev_v;
  int         w;
  string      nm [3];

  initial begin
    nm[0] = "d0"; nm[1] = "d1"; nm[2] = "d3";
    for (int k = 0; k < 3; k++) begin
      fs2[k] = -1; da_cnt[k] = 0; vs_cnt[k] = 0; fe_at[k] = -1;
    end

    // reset held 5 clocks
    rst_n = 1'b0;
    repeat (5) step();
    chk("rst_h", int'(f_h), 0);
    chk("rst_v", int'(f_v), 0);
    chk("rst_frame_start", int'(f_fs), 1);
    chk("rst_line_start", int'(f_ls), 1);
    chk("rst_display_area", int'(f_da), 1);
    chk("rst_hsync", int'(f_hs), 1);
    chk("rst_vsync", int'(f_vs), 1);
    chk("rst_blank_n", int'(f_bn), 0);

    rst_n = 1'b1;
    prev_v = f_v;
    for (int c = 0; c <= 800; c++) begin
      if (c > 0) step();
      if (f_v != prev_v) f_vchg++;
      prev_v = f_v;
      if (c < 800 && !f_hs) begin
        f_lo_cnt++;
        if (f_first_lo < 0) f_first_lo = c;
        f_last_lo = c;
      end
      case (c)
        0: begin
          chk("c0_h", int'(f_h), 0);
          chk("c0_frame_start", int'(f_fs), 1);
          chk("c0_hsync", int'(f_hs), 1);
          chk("c0_vsync", int'(f_vs), 1);
          chk("c0_blank_n", int'(f_bn), 0);
        end
        1: begin
          chk("c1_h", int'(f_h), 1);
          chk("c1_frame_start", int'(f_fs), 0);
          chk("c1_line_start", int'(f_ls), 0);
          chk("c1_blank_n", int'(f_bn), 1);
        end
        639: chk("c639_display_area", int'(f_da), 1);
        640: begin
          chk("c640_display_area", int'(f_da), 0);
          chk("c640_blank_n", int'(f_bn), 1);
        end
        641: chk("c641_blank_n", int'(f_bn), 0);
        799: begin
          chk("c799_h", int'(f_h), 799);
          chk("c799_v", int'(f_v), 0);
        end
        800: begin
          chk("c800_h", int'(f_h), 0);
          chk("c800_v", int'(f_v), 1);
          chk("c800_line_start", int'(f_ls), 1);
          chk("c800_frame_start", int'(f_fs), 0);
        end
        default: ;
      endcase

      s0_hs_hist[c] = s0_hs;
      s0_bn_hist[c] = s0_bn;
      if (c < 25 && !s0_hs) begin
        s0_lo_line0++;
        if (s0_first_lo < 0) s0_first_lo = c;
      end
      if (c >= 1 && s1_bn !== s0_bn_hist[c-1]) sh1_err++;
      if (c >= 3 && (s3_hs !== s0_hs_hist[c-3] || s3_bn !== s0_bn_hist[c-3])) sh3_err++;
      if (c < 3 && (s3_bn || !s3_hs || !s3_vs)) s3_early++;
      for (int k = 0; k < 3; k++) begin
        if (c < 325) begin
          da_cnt[k] += int'(da_v[k]);
          vs_cnt[k] += int'(!vs_v[k]);
          if (fe_v[k] && fe_at[k] < 0) fe_at[k] = c;
        end
        if (c > 0 && fs_v[k] && fs2[k] < 0) fs2[k] = c;
      end
    end

    chk("line_hsync_low_clks", f_lo_cnt, 96);
    chk("line_hsync_first_low", f_first_lo, 657);
    chk("line_hsync_last_low", f_last_lo, 752);
    chk("line_v_changes", f_vchg, 1);
    chk("d0_raw_hsync_low_clks", s0_lo_line0, 4);
    chk("d0_raw_hsync_first_low", s0_first_lo, 18);
    chk("d1_blank_shift_err", sh1_err, 0);
    chk("d3_shift_err", sh3_err, 0);
    chk("d3_hold_inactive_err", s3_early, 0);
    for (int k = 0; k < 3; k++) begin
      chk({nm[k], "_frame_period"}, fs2[k], 325);
      chk({nm[k], "_display_clks"}, da_cnt[k], 96);
      chk({nm[k], "_vsync_low_clks"}, vs_cnt[k], 50);
      chk({nm[k], "_frame_end_at"}, fe_at[k], 141);
    end

    // reset mid-hsync and mid-vsync on the small raster
    w = 0;
    while (!(s0_h == 10'd20 && s0_v == 10'd8) && w < 400) begin
      step();
      w++;
    end
    chk("mid_point_reached", int'(s0_h == 10'd20 && s0_v == 10'd8), 1);
    chk("mid_pre_hsync", int'(s1_hs), 0);
    chk("mid_pre_vsync", int'(s1_vs), 0);
    rst_n = 1'b0;
    step();
    chk("mid_rst_h", int'(s1_h), 0);
    chk("mid_rst_v", int'(s1_v), 0);
    chk("mid_rst_full_h", int'(f_h), 0);
    chk("mid_rst_d1_hsync", int'(s1_hs), 1);
    chk("mid_rst_d1_vsync", int'(s1_vs), 1);
    chk("mid_rst_d3_hsync", int'(s3_hs), 1);
    chk("mid_rst_d3_vsync", int'(s3_vs), 1);
    chk("mid_rst_d0_hsync", int'(s0_hs), 1);
    chk("mid_rst_d1_blank_n", int'(s1_bn), 0);
    rst_n = 1'b1;
    for (int k = 0; k <= 3; k++) begin
      if (k > 0) step();
      chk($sformatf("rel_d3_blank_n_%0d", k), int'(s3_bn), (k == 3) ? 1 : 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
